// File: rtl/tl_chk_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tl_chk_pkg
//  Brief    : Opcodes, error codes and beat arithmetic shared by the TL checker.
//  Revision : 1.0 - initial release
// ============================================================================
package tl_chk_pkg;

    localparam logic [2:0] A_PUT_FULL        = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] A_GET             = 3'd4;
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [3:0] {
        ERR_NONE     = 4'd0,
        ERR_A_BUSY   = 4'd1,
        ERR_A_ALIGN  = 4'd2,
        ERR_A_BURST  = 4'd3,
        ERR_A_STALL  = 4'd4,
        ERR_D_IDLE   = 4'd5,
        ERR_D_EXPECT = 4'd6,
        ERR_D_BURST  = 4'd7,
        ERR_TIMEOUT  = 4'd8
    } err_code_e;

    // Only data-carrying messages larger than one beat span several beats.
    function automatic int unsigned beats_from_size(input logic data,
                                                    input int unsigned size,
                                                    input int unsigned beat_lg);
        if (!data || size <= beat_lg) return 32'd1;
        return 32'd1 << (size - beat_lg);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_chk_burst.sv
`default_nettype none
// ============================================================================
//  Module   : tl_chk_burst
//  Brief    : Per-channel beat counter, first-beat capture, mid-burst and
//             stall-stability compare for one TileLink channel.
//  Revision : 1.0 - initial release
// ============================================================================
module tl_chk_burst
    import tl_chk_pkg::*;
#(
    parameter int SOURCE_W = 2,
    parameter int ADDR_W   = 30,
    parameter int SIZE_W   = 3,
    parameter int BEAT_LG  = 2,
    parameter bit IS_A     = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                valid_i,
    input  logic                ready_i,
    input  logic [2:0]          opcode_i,
    input  logic [SIZE_W-1:0]   size_i,
    input  logic [SOURCE_W-1:0] source_i,
    input  logic [ADDR_W-1:0]   address_i,
    output logic                first_o,
    output logic                last_o,
    output logic                mismatch_o,
    output logic                unstable_o
);

    localparam int CNT_W = ((1 << SIZE_W) > BEAT_LG) ? ((1 << SIZE_W) - BEAT_LG + 1) : 1;

    logic [CNT_W-1:0]    cnt_q, cnt_d, idx_q, idx_d, w_beats;
    logic [2:0]          cap_op_q, prv_op_q;
    logic [SIZE_W-1:0]   cap_size_q, prv_size_q;
    logic [SOURCE_W-1:0] cap_src_q, prv_src_q;
    logic [ADDR_W-1:0]   cap_addr_q, prv_addr_q, w_exp_addr;
    logic                cap_data_q, stall_q;
    logic                w_fire, w_idle, w_data;

    assign w_fire  = valid_i & ready_i;
    assign w_idle  = (cnt_q == '0);
    assign w_data  = IS_A ? (opcode_i == A_PUT_FULL || opcode_i == A_PUT_PARTIAL)
                          : (opcode_i == D_ACCESS_ACK_DATA);
    assign w_beats = CNT_W'(beats_from_size(w_data, 32'(size_i), BEAT_LG));

    // Put beats walk the address upward one beat at a time; everything else repeats it.
    assign w_exp_addr = cap_addr_q + ((IS_A && cap_data_q) ? (ADDR_W'(idx_q) << BEAT_LG) : '0);

    assign first_o    = w_fire & w_idle;
    assign last_o     = w_fire & (w_idle ? (w_beats == CNT_W'(1)) : (cnt_q == CNT_W'(1)));
    assign mismatch_o = w_fire & !w_idle &
                        ((opcode_i != cap_op_q) || (size_i != cap_size_q) ||
                         (source_i != cap_src_q) || (IS_A && (address_i != w_exp_addr)));
    assign unstable_o = stall_q &
                        (!valid_i || (opcode_i != prv_op_q) || (size_i != prv_size_q) ||
                         (source_i != prv_src_q) || (address_i != prv_addr_q));

    always_comb begin
        cnt_d = cnt_q;
        idx_d = idx_q;
        if (w_fire) begin
            if (w_idle) begin
                cnt_d = w_beats - CNT_W'(1);
                idx_d = CNT_W'(1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
                idx_d = idx_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            cap_op_q   <= '0;
            cap_size_q <= '0;
            cap_src_q  <= '0;
            cap_addr_q <= '0;
            cap_data_q <= 1'b0;
            stall_q    <= 1'b0;
            prv_op_q   <= '0;
            prv_size_q <= '0;
            prv_src_q  <= '0;
            prv_addr_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stall_q <= valid_i & !ready_i;
            if (first_o) begin
                cap_op_q   <= opcode_i;
                cap_size_q <= size_i;
                cap_src_q  <= source_i;
                cap_addr_q <= address_i;
                cap_data_q <= w_data;
            end
            prv_op_q   <= opcode_i;
            prv_size_q <= size_i;
            prv_src_q  <= source_i;
            prv_addr_q <= address_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tl_inflight_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tl_inflight_checker
//  Brief    : TileLink-UL A/D protocol checker with per-source in-flight table
//             and sticky first-error capture. Optional macro
//             TL_CHECK_TIMEOUT_EN builds per-source response timeouts.
//  Revision : 1.0 - initial release
// ============================================================================
module tl_inflight_checker
    import tl_chk_pkg::*;
#(
    parameter int SOURCE_W     = 2,
    parameter int ADDR_W       = 30,
    parameter int SIZE_W       = 3,
    parameter int BEAT_LG      = 2,
    parameter int TIMEOUT      = 1024,
    parameter bit FATAL_ON_ERR = 1'b1
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                a_valid,
    input  logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [SIZE_W-1:0]   a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [ADDR_W-1:0]   a_address,
    input  logic                d_valid,
    input  logic                d_ready,
    input  logic [2:0]          d_opcode,
    input  logic [SIZE_W-1:0]   d_size,
    input  logic [SOURCE_W-1:0] d_source,
    output logic                err_valid,
    output logic [3:0]          err_code,
    output logic [SOURCE_W-1:0] err_source,
    output logic [7:0]          err_count,
    output logic [SOURCE_W:0]   inflight
);

    localparam int NSRC = 1 << SOURCE_W;

    logic w_a_first, w_a_mism, w_a_unst, w_a_last_unused;
    logic w_d_first, w_d_last, w_d_mism, w_d_unst;

    tl_chk_burst #(.SOURCE_W(SOURCE_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W),
                   .BEAT_LG(BEAT_LG), .IS_A(1'b1)) u_a_burst (
        .clk_i(clock), .rst_ni(reset_n), .valid_i(a_valid), .ready_i(a_ready),
        .opcode_i(a_opcode), .size_i(a_size), .source_i(a_source), .address_i(a_address),
        .first_o(w_a_first), .last_o(w_a_last_unused), .mismatch_o(w_a_mism), .unstable_o(w_a_unst)
    );

    tl_chk_burst #(.SOURCE_W(SOURCE_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W),
                   .BEAT_LG(BEAT_LG), .IS_A(1'b0)) u_d_burst (
        .clk_i(clock), .rst_ni(reset_n), .valid_i(d_valid), .ready_i(d_ready),
        .opcode_i(d_opcode), .size_i(d_size), .source_i(d_source), .address_i('0),
        .first_o(w_d_first), .last_o(w_d_last), .mismatch_o(w_d_mism), .unstable_o(w_d_unst)
    );

    logic [NSRC-1:0]             busy_q, busy_d, exp_op_q, exp_op_d, w_tmo;
    logic [NSRC-1:0][SIZE_W-1:0] exp_size_q, exp_size_d;
    logic [ADDR_W-1:0]           w_align_mask;
    logic [SOURCE_W:0]           w_inflight;
    logic                        err_valid_q, w_any, w_tmo_any;
    err_code_e                   err_code_q, w_code;
    logic [SOURCE_W-1:0]         err_src_q, w_src, w_tmo_src;
    logic [7:0]                  err_count_q;
    logic                        e1, e2, e3, e4, e5, e6, e7;

    // D retires before A allocates, so a same-cycle hand-over is legal.
    always_comb begin
        busy_d     = busy_q;
        exp_op_d   = exp_op_q;
        exp_size_d = exp_size_q;
        if (w_d_last) busy_d[d_source] = 1'b0;
        if (w_a_first) begin
            busy_d[a_source]     = 1'b1;
            exp_op_d[a_source]   = (a_opcode == A_GET);
            exp_size_d[a_source] = a_size;
        end
    end

`ifdef TL_CHECK_TIMEOUT_EN
    localparam int AGE_W = $clog2(TIMEOUT + 1);
    logic [NSRC-1:0][AGE_W-1:0] age_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            age_q <= '0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if ((w_a_first && a_source == SOURCE_W'(i)) || !busy_d[i])
                    age_q[i] <= '0;
                else if (age_q[i] != AGE_W'(TIMEOUT))
                    age_q[i] <= age_q[i] + AGE_W'(1);
            end
        end
    end

    always_comb begin
        w_tmo = '0;
        for (int i = 0; i < NSRC; i++)
            w_tmo[i] = busy_q[i] && !(w_d_last && d_source == SOURCE_W'(i)) &&
                       (age_q[i] == AGE_W'(TIMEOUT - 1));
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign w_tmo          = '0;
`endif

    always_comb begin
        w_tmo_any = |w_tmo;
        w_tmo_src = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (w_tmo[i]) w_tmo_src = SOURCE_W'(i);
    end

    assign w_align_mask = (ADDR_W'(1) << a_size) - ADDR_W'(1);

    assign e1 = w_a_first & busy_q[a_source] & !(w_d_last && d_source == a_source);
    assign e2 = w_a_first & ((a_address & w_align_mask) != '0);
    assign e3 = w_a_mism;
    assign e4 = w_a_unst;
    assign e5 = w_d_first & !busy_q[d_source];
    assign e6 = w_d_first & busy_q[d_source] &
                ((d_opcode != (exp_op_q[d_source] ? D_ACCESS_ACK_DATA : D_ACCESS_ACK)) ||
                 (d_size != exp_size_q[d_source]));
    assign e7 = w_d_mism | w_d_unst;

    always_comb begin
        w_code = ERR_NONE;
        w_src  = '0;
        if      (e1)        begin w_code = ERR_A_BUSY;   w_src = a_source;  end
        else if (e2)        begin w_code = ERR_A_ALIGN;  w_src = a_source;  end
        else if (e3)        begin w_code = ERR_A_BURST;  w_src = a_source;  end
        else if (e4)        begin w_code = ERR_A_STALL;  w_src = a_source;  end
        else if (e5)        begin w_code = ERR_D_IDLE;   w_src = d_source;  end
        else if (e6)        begin w_code = ERR_D_EXPECT; w_src = d_source;  end
        else if (e7)        begin w_code = ERR_D_BURST;  w_src = d_source;  end
        else if (w_tmo_any) begin w_code = ERR_TIMEOUT;  w_src = w_tmo_src; end
    end

    assign w_any = (w_code != ERR_NONE);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            busy_q      <= '0;
            exp_op_q    <= '0;
            exp_size_q  <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_src_q   <= '0;
            err_count_q <= '0;
        end else begin
            busy_q     <= busy_d;
            exp_op_q   <= exp_op_d;
            exp_size_q <= exp_size_d;
            if (w_any && !err_valid_q) begin
                err_valid_q <= 1'b1;
                err_code_q  <= w_code;
                err_src_q   <= w_src;
            end
            if (w_any && err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
        end
    end

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < NSRC; i++)
            w_inflight = w_inflight + (SOURCE_W + 1)'(busy_q[i]);
    end

    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign err_source = err_src_q;
    assign err_count  = err_count_q;
    assign inflight   = w_inflight;

`ifndef SYNTHESIS
    generate
        if (FATAL_ON_ERR) begin : g_fatal
            always_ff @(posedge clock) begin
                if (reset_n && w_any && !err_valid_q)
                    $fatal(1, "tl_inflight_checker: protocol error code %0d source %0d",
                           w_code, w_src);
            end
        end
    endgenerate
`endif

endmodule
`default_nettype wire

// File: tb/tb_tl_inflight_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tl_inflight_checker
//  Brief    : Directed self-checking bench for tl_inflight_checker.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tl_inflight_checker;

    localparam int SOURCE_W = 2;
    localparam int ADDR_W   = 30;
    localparam int SIZE_W   = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                a_valid, a_ready, d_valid, d_ready;
    logic [2:0]          a_opcode, d_opcode;
    logic [SIZE_W-1:0]   a_size, d_size;
    logic [SOURCE_W-1:0] a_source, d_source;
    logic [ADDR_W-1:0]   a_address;
    logic                err_valid;
    logic [3:0]          err_code;
    logic [SOURCE_W-1:0] err_source;
    logic [7:0]          err_count;
    logic [SOURCE_W:0]   inflight;

    int n_checks = 0;
    int n_errors = 0;

    tl_inflight_checker #(
        .SOURCE_W(SOURCE_W), .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .BEAT_LG(2),
        .TIMEOUT(16), .FATAL_ON_ERR(1'b0)
    ) dut (
        .clock(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_size(a_size),
        .a_source(a_source), .a_address(a_address),
        .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_size(d_size),
        .d_source(d_source),
        .err_valid(err_valid), .err_code(err_code), .err_source(err_source),
        .err_count(err_count), .inflight(inflight)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 1'b0; d_valid = 1'b0; a_ready = 1'b1; d_ready = 1'b1;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
    endtask

    task automatic a_send(input logic [2:0] op, input int sz, input int src, input int addr);
        a_valid = 1'b1; a_ready = 1'b1; a_opcode = op;
        a_size = SIZE_W'(sz); a_source = SOURCE_W'(src); a_address = ADDR_W'(addr);
        tick(1);
        a_valid = 1'b0;
    endtask

    task automatic d_send(input logic [2:0] op, input int sz, input int src);
        d_valid = 1'b1; d_ready = 1'b1; d_opcode = op;
        d_size = SIZE_W'(sz); d_source = SOURCE_W'(src);
        tick(1);
        d_valid = 1'b0;
    endtask

    initial begin
        a_opcode = '0; a_size = '0; a_source = '0; a_address = '0;
        d_opcode = '0; d_size = '0; d_source = '0;
        do_reset();
        check_val("rst_err_valid", int'(err_valid), 0);
        check_val("rst_err_code", int'(err_code), 0);
        check_val("rst_err_count", int'(err_count), 0);
        check_val("rst_inflight", int'(inflight), 0);

        // Clean Get / AccessAckData round trip
        a_send(3'd4, 2, 1, 'h100);
        check_val("get_inflight_1", int'(inflight), 1);
        tick(4);
        d_send(3'd1, 2, 1);
        check_val("get_inflight_0", int'(inflight), 0);
        check_val("get_no_err", int'(err_valid), 0);

        // 4-beat PutFull with a bad third-beat address
        do_reset();
        a_send(3'd0, 4, 2, 'h100);
        a_send(3'd0, 4, 2, 'h104);
        check_val("put_beat2_clean", int'(err_valid), 0);
        a_send(3'd0, 4, 2, 'h10C);
        check_val("put_err_valid", int'(err_valid), 1);
        check_val("put_err_code", int'(err_code), 3);
        check_val("put_err_source", int'(err_source), 2);
        a_send(3'd0, 4, 2, 'h10C);
        check_val("put_err_count", int'(err_count), 1);
        check_val("put_inflight", int'(inflight), 1);

        // Second Get on a busy source
        do_reset();
        a_send(3'd4, 2, 2, 'h200);
        a_send(3'd4, 2, 2, 'h200);
        check_val("busy_err_code", int'(err_code), 1);
        check_val("busy_err_source", int'(err_source), 2);

        // D last beat and new A on the same source in one cycle is legal
        do_reset();
        a_send(3'd4, 2, 2, 'h200);
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 3'd2; a_source = 2'd2; a_address = 'h200;
        d_valid = 1'b1; d_opcode = 3'd1; d_size = 3'd2; d_source = 2'd2;
        tick(1);
        a_valid = 1'b0; d_valid = 1'b0;
        check_val("handover_no_err", int'(err_valid), 0);
        check_val("handover_inflight", int'(inflight), 1);
        d_send(3'd1, 2, 2);
        check_val("handover_done", int'(inflight), 0);
        check_val("handover_still_clean", int'(err_valid), 0);

        // D on idle source, then a later misaligned A
        do_reset();
        d_send(3'd0, 2, 3);
        check_val("idle_err_code", int'(err_code), 5);
        check_val("idle_err_source", int'(err_source), 3);
        a_send(3'd4, 2, 0, 'h102);
        check_val("sticky_err_code", int'(err_code), 5);
        check_val("sticky_err_count", int'(err_count), 2);
        check_val("sticky_inflight", int'(inflight), 1);

        // Wrong D opcode for a Get
        do_reset();
        a_send(3'd4, 2, 0, 'h40);
        d_send(3'd0, 2, 0);
        check_val("expect_err_code", int'(err_code), 6);

        // Unanswered Get: timeout only in the timeout build
        do_reset();
        a_send(3'd4, 2, 1, 'h0);
        tick(15);
        check_val("tmo_before", int'(err_valid), 0);
        tick(1);
`ifdef TL_CHECK_TIMEOUT_EN
        check_val("tmo_err_valid", int'(err_valid), 1);
        check_val("tmo_err_code", int'(err_code), 8);
        check_val("tmo_err_source", int'(err_source), 1);
`else
        check_val("tmo_disabled", int'(err_valid), 0);
        tick(20);
        check_val("tmo_disabled_late", int'(err_valid), 0);
`endif

        // Address changed while stalled
        do_reset();
        a_valid = 1'b1; a_ready = 1'b0; a_opcode = 3'd4; a_size = 3'd2;
        a_source = 2'd0; a_address = 'h40;
        tick(1);
        a_address = 'h44;
        tick(1);
        a_valid = 1'b0;
        check_val("stall_err_code", int'(err_code), 4);
        check_val("stall_err_source", int'(err_source), 0);

        // Reset mid-burst, then a fresh clean burst
        do_reset();
        a_send(3'd0, 4, 1, 'h0);
        a_send(3'd0, 4, 1, 'h4);
        do_reset();
        check_val("midrst_err_valid", int'(err_valid), 0);
        check_val("midrst_inflight", int'(inflight), 0);
        check_val("midrst_err_count", int'(err_count), 0);
        a_send(3'd0, 4, 1, 'h0);
        a_send(3'd0, 4, 1, 'h4);
        a_send(3'd0, 4, 1, 'h8);
        a_send(3'd0, 4, 1, 'hC);
        check_val("fresh_inflight", int'(inflight), 1);
        d_send(3'd0, 4, 1);
        check_val("fresh_done", int'(inflight), 0);
        check_val("fresh_no_err", int'(err_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
